// File: rtl/flash_rom_pkg.sv
// Shared types and helpers for the flash ROM line interface.
// Covers bus access-size codes, sequencer states and big-endian read-data extraction.
package flash_rom_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic [1:0] {
    RESET_PULSE = 2'b00,
    IDLE        = 2'b01,
    FILL        = 2'b10
  } state_e;

  // Big-endian item selection; the item is zero-extended into the low bits.
  function automatic logic [31:0] extract_read_data(input logic [1:0]  size,
                                                    input logic [1:0]  addr_lo,
                                                    input logic [31:0] word);
    logic [31:0] data;
    case (size)
      SIZE_HALF: begin
        if (addr_lo[1]) begin
          data = {16'h0000, word[15:0]};
        end else begin
          data = {16'h0000, word[31:16]};
        end
      end
      SIZE_BYTE: begin
        case (addr_lo)
          2'b00:   data = {24'h000000, word[31:24]};
          2'b01:   data = {24'h000000, word[23:16]};
          2'b10:   data = {24'h000000, word[15:8]};
          default: data = {24'h000000, word[7:0]};
        endcase
      end
      default: data = word;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/flash_rom_line_interface_buffer.sv
// Single-line read buffer: LINE_WORDS x 32-bit storage filled one halfword at a time,
// with a tag/valid pair giving a combinational hit and word-select read port.
module flash_line_buffer
  import flash_rom_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int TAG_BITS   = 17,
  parameter int HW_BITS    = 3,
  parameter int WORD_BITS  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fill_start_i,
  input  logic [TAG_BITS-1:0]  fill_tag_i,
  input  logic                 fill_done_i,
  input  logic                 wr_en_i,
  input  logic [HW_BITS-1:0]   wr_idx_i,
  input  logic [15:0]          wr_data_i,
  input  logic [TAG_BITS-1:0]  lookup_tag_i,
  input  logic [WORD_BITS-1:0] rd_sel_i,
  output logic                 hit_o,
  output logic [31:0]          rd_word_o,
  output logic [TAG_BITS-1:0]  line_tag_o
);

  logic [31:0]         mem_q [LINE_WORDS];
  logic [TAG_BITS-1:0] tag_q;
  logic                valid_q;
  logic [WORD_BITS-1:0] wr_word_s;

  assign wr_word_s = WORD_BITS'(wr_idx_i >> 1);

  // Tag/valid: starting a fill invalidates the line until its last halfword lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q   <= TAG_BITS'(0);
      valid_q <= 1'b0;
    end else if (fill_start_i) begin
      tag_q   <= fill_tag_i;
      valid_q <= 1'b0;
    end else if (fill_done_i) begin
      valid_q <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Halfword write port: even index is the high half of the word.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      if (wr_idx_i[0]) begin
        mem_q[wr_word_s][15:0] <= wr_data_i;
      end else begin
        mem_q[wr_word_s][31:16] <= wr_data_i;
      end
    end
  end

  assign hit_o      = valid_q && (tag_q == lookup_tag_i);
  assign rd_word_o  = mem_q[rd_sel_i];
  assign line_tag_o = tag_q;

endmodule

// File: rtl/flash_rom_line_interface.sv
// Eco32 bus to x16 NOR flash bridge: reset-pulse generator, line-fill sequencer
// and zero-wait hit path through a single-line read buffer.
module flash_rom_line_interface
  import flash_rom_pkg::*;
#(
  parameter int BUS_ADDRESS_WIDTH = 21,
  parameter int LINE_WORDS        = 4,
  parameter int ACCESS_CYCLES     = 8,
  parameter int PAGE_CYCLES       = 3,
  parameter int RESET_CYCLES      = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         busEnable,
  input  logic                         busWrite,
  input  logic [1:0]                   busAccessSize,
  input  logic [BUS_ADDRESS_WIDTH-1:0] busAddress,
  input  logic [31:0]                  busWriteData,
  output logic [31:0]                  busReadData,
  output logic                         busWait,
  output logic                         romChipEnableInverted,
  output logic                         romOutputEnableInverted,
  output logic                         romWriteEnableInverted,
  output logic                         romResetInverted,
  output logic                         romByteInverted,
  output logic [BUS_ADDRESS_WIDTH-2:0] romAddress,
  input  logic [15:0]                  romData
);

  localparam int OFFSET_BITS = $clog2(LINE_WORDS * 4);
  localparam int TAG_BITS    = BUS_ADDRESS_WIDTH - OFFSET_BITS;
  localparam int HW_BITS     = $clog2(2 * LINE_WORDS);
  localparam int WORD_BITS   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int MAX_CYCLES  = (ACCESS_CYCLES > PAGE_CYCLES) ? ACCESS_CYCLES : PAGE_CYCLES;
  localparam int CYC_BITS    = $clog2(MAX_CYCLES + 1);
  localparam int RST_BITS    = $clog2(RESET_CYCLES + 1);

  state_e              state_q, state_d;
  logic [RST_BITS-1:0] rst_cnt_q, rst_cnt_d;
  logic [CYC_BITS-1:0] cyc_q, cyc_d;
  logic [HW_BITS-1:0]  hw_idx_q, hw_idx_d;
  logic                ce_n_q, ce_n_d;
  logic                rom_rst_n_q, rom_rst_n_d;

  logic                 fill_start_s, fill_done_s, wr_en_s, hit_s;
  logic [TAG_BITS-1:0]  tag_s, line_tag_s;
  logic [WORD_BITS-1:0] word_sel_s;
  logic [31:0]          buf_word_s;
  logic [CYC_BITS-1:0]  last_cyc_s;
  logic                 unused_s;

  assign tag_s      = busAddress[BUS_ADDRESS_WIDTH-1:OFFSET_BITS];
  assign word_sel_s = (LINE_WORDS == 1) ? WORD_BITS'(0) : WORD_BITS'(busAddress >> 2);
  assign last_cyc_s = (hw_idx_q == HW_BITS'(0)) ? CYC_BITS'(ACCESS_CYCLES - 1)
                                                : CYC_BITS'(PAGE_CYCLES - 1);
  assign unused_s   = ^busWriteData;

  flash_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .TAG_BITS   (TAG_BITS),
    .HW_BITS    (HW_BITS),
    .WORD_BITS  (WORD_BITS)
  ) u_buffer (
    .clock        (clock),
    .reset        (reset),
    .fill_start_i (fill_start_s),
    .fill_tag_i   (tag_s),
    .fill_done_i  (fill_done_s),
    .wr_en_i      (wr_en_s),
    .wr_idx_i     (hw_idx_q),
    .wr_data_i    (romData),
    .lookup_tag_i (tag_s),
    .rd_sel_i     (word_sel_s),
    .hit_o        (hit_s),
    .rd_word_o    (buf_word_s),
    .line_tag_o   (line_tag_s)
  );

  // Sequencer state and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RESET_PULSE;
      rst_cnt_q   <= RST_BITS'(0);
      cyc_q       <= CYC_BITS'(0);
      hw_idx_q    <= HW_BITS'(0);
      ce_n_q      <= 1'b1;
      rom_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cyc_q       <= cyc_d;
      hw_idx_q    <= hw_idx_d;
      ce_n_q      <= ce_n_d;
      rom_rst_n_q <= rom_rst_n_d;
    end
  end

  // Next-state: reset pulse, miss detection and halfword stepping of the fill.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    cyc_d        = cyc_q;
    hw_idx_d     = hw_idx_q;
    ce_n_d       = ce_n_q;
    rom_rst_n_d  = rom_rst_n_q;
    fill_start_s = 1'b0;
    fill_done_s  = 1'b0;
    wr_en_s      = 1'b0;
    case (state_q)
      RESET_PULSE: begin
        if (rst_cnt_q == RST_BITS'(RESET_CYCLES - 1)) begin
          state_d     = IDLE;
          rst_cnt_d   = RST_BITS'(0);
          rom_rst_n_d = 1'b1;
        end else begin
          rst_cnt_d   = rst_cnt_q + RST_BITS'(1);
          rom_rst_n_d = 1'b0;
        end
      end
      IDLE: begin
        if (busEnable && !busWrite && !hit_s) begin
          state_d      = FILL;
          cyc_d        = CYC_BITS'(0);
          hw_idx_d     = HW_BITS'(0);
          ce_n_d       = 1'b0;
          fill_start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (cyc_q == last_cyc_s) begin
          wr_en_s = 1'b1;
          cyc_d   = CYC_BITS'(0);
          // Index stays on the last halfword so the flash address never wraps.
          if (hw_idx_q == HW_BITS'(2 * LINE_WORDS - 1)) begin
            fill_done_s = 1'b1;
            state_d     = IDLE;
            ce_n_d      = 1'b1;
          end else begin
            hw_idx_d = hw_idx_q + HW_BITS'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_BITS'(1);
        end
      end
      default: begin
        state_d = RESET_PULSE;
        ce_n_d  = 1'b1;
      end
    endcase
  end

  // Bus response: hits and writes finish in the same cycle, everything else waits.
  always_comb begin
    busWait     = busEnable;
    busReadData = 32'h0000_0000;
    if (!reset && (state_q == IDLE) && busEnable) begin
      if (busWrite) begin
        busWait = 1'b0;
      end else if (hit_s) begin
        busWait     = 1'b0;
        busReadData = extract_read_data(busAccessSize, busAddress[1:0], buf_word_s);
      end else begin
        busWait = 1'b1;
      end
    end else begin
      busWait = busEnable;
    end
  end

  assign romChipEnableInverted   = ce_n_q;
  assign romOutputEnableInverted = ce_n_q;
  assign romWriteEnableInverted  = 1'b1;
  assign romByteInverted         = 1'b1;
  assign romResetInverted        = rom_rst_n_q;
  assign romAddress              = {line_tag_s, hw_idx_q};

endmodule

// File: tb/tb_flash_rom_line_interface.sv
// Directed bench for flash_rom_line_interface: a flash model returning 0x1000+n for
// halfword n, a hit-vector table and hand-written miss/reset sequences.
module tb_flash_rom_line_interface;

  localparam int BAW  = 21;
  localparam int ACC  = 8;
  localparam int PAGE = 3;
  localparam int LAT  = 1 + ACC + 7 * PAGE;
  localparam int NV   = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic            busEnable, busWrite;
  logic [1:0]      busAccessSize;
  logic [BAW-1:0]  busAddress;
  logic [31:0]     busWriteData, busReadData;
  logic            busWait;
  logic            ce_n, oe_n, we_n, rst_n, byte_n;
  logic [BAW-2:0]  romAddress;
  logic [15:0]     romData;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        en;
    logic        wr;
    logic [1:0]  sz;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic        exp_wait;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [NV];

  flash_rom_line_interface dut (
    .clock                   (clock),
    .reset                   (reset),
    .busEnable               (busEnable),
    .busWrite                (busWrite),
    .busAccessSize           (busAccessSize),
    .busAddress              (busAddress),
    .busWriteData            (busWriteData),
    .busReadData             (busReadData),
    .busWait                 (busWait),
    .romChipEnableInverted   (ce_n),
    .romOutputEnableInverted (oe_n),
    .romWriteEnableInverted  (we_n),
    .romResetInverted        (rst_n),
    .romByteInverted         (byte_n),
    .romAddress              (romAddress),
    .romData                 (romData)
  );

  always #5 clock = ~clock;

  assign romData = 16'h1000 + romAddress[15:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts cycles with romResetInverted low; ends in the first IDLE cycle.
  task automatic measure_pulse(input string name);
    int n = 0;
    int bad = 0;
    while (rst_n === 1'b0 && n < 200) begin
      if (busEnable && busWait !== 1'b1) bad++;
      if (ce_n !== 1'b1) bad++;
      tick();
      n++;
    end
    check({name, " pulse length"}, 32'(n), 32'd64);
    check({name, " wait/ce during pulse"}, 32'(bad), 32'd0);
  endtask

  // Issues (or keeps) a read in the current cycle and follows the whole line fill.
  task automatic read_miss(input string name, input logic [BAW-1:0] a,
                           input logic [1:0] sz, input logic [31:0] exp);
    int lat = 0;
    int bad_pins = 0;
    int bad_addr = 0;
    int exp_hw;
    logic [BAW-2:0] base;
    busEnable = 1'b1; busWrite = 1'b0; busAddress = a; busAccessSize = sz;
    base = (BAW-1)'((a >> 4) << 3);
    #1;
    check({name, " wait at accept"}, {31'd0, busWait}, 32'd1);
    while (busWait === 1'b1 && lat < 200) begin
      tick();
      lat++;
      if (busWait === 1'b1) begin
        if (ce_n !== 1'b0 || oe_n !== 1'b0) bad_pins++;
        exp_hw = (lat <= ACC) ? 0 : 1 + (lat - ACC - 1) / PAGE;
        if (romAddress !== base + (BAW-1)'(exp_hw)) bad_addr++;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(LAT));
    check({name, " data"}, busReadData, exp);
    check({name, " ce/oe high at end"}, {30'd0, ce_n, oe_n}, 32'd3);
    check({name, " ce/oe low during fill"}, 32'(bad_pins), 32'd0);
    check({name, " address sequence"}, 32'(bad_addr), 32'd0);
    tick();
    busEnable = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 21'h000004, 32'h0, 1'b0, 1'b1, 32'h10021003};
    vecs[1]  = '{1'b1, 1'b0, 2'b01, 21'h000006, 32'h0, 1'b0, 1'b1, 32'h00001003};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 21'h000007, 32'h0, 1'b0, 1'b1, 32'h00000003};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 21'h000000, 32'h0, 1'b0, 1'b1, 32'h10001001};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 21'h000003, 32'h0, 1'b0, 1'b1, 32'h10001001};
    vecs[5]  = '{1'b1, 1'b0, 2'b11, 21'h000008, 32'h0, 1'b0, 1'b1, 32'h10041005};
    vecs[6]  = '{1'b1, 1'b0, 2'b01, 21'h000000, 32'h0, 1'b0, 1'b1, 32'h00001000};
    vecs[7]  = '{1'b1, 1'b0, 2'b01, 21'h000003, 32'h0, 1'b0, 1'b1, 32'h00001001};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 21'h000008, 32'h0, 1'b0, 1'b1, 32'h00000010};
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 21'h000009, 32'h0, 1'b0, 1'b1, 32'h00000004};
    vecs[10] = '{1'b1, 1'b0, 2'b10, 21'h00000D, 32'h0, 1'b0, 1'b1, 32'h00000006};
    vecs[11] = '{1'b1, 1'b0, 2'b10, 21'h00000F, 32'h0, 1'b0, 1'b1, 32'h00000007};
    vecs[12] = '{1'b1, 1'b1, 2'b00, 21'h000004, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 2'b00, 21'h000004, 32'h0, 1'b0, 1'b1, 32'h10021003};
    vecs[14] = '{1'b1, 1'b1, 2'b00, 21'h000100, 32'h12345678, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 1'b0, 2'b00, 21'h000004, 32'h0, 1'b0, 1'b1, 32'h00000000};

    reset = 1'b1; busEnable = 1'b1; busWrite = 1'b0; busAccessSize = 2'b00;
    busAddress = 21'h000000; busWriteData = 32'h0;
    tick(); tick(); tick();
    check("reset rom reset low", {31'd0, rst_n}, 32'd0);
    check("reset ce/oe high", {30'd0, ce_n, oe_n}, 32'd3);
    check("reset rom address", 32'(romAddress), 32'd0);
    check("reset busWait", {31'd0, busWait}, 32'd1);
    check("reset we/byte high", {30'd0, we_n, byte_n}, 32'd3);
    reset = 1'b0;
    measure_pulse("power-up");

    // Held request for line 0 is accepted in the first IDLE cycle.
    read_miss("line0 word 0x0", 21'h000000, 2'b00, 32'h10001001);
    read_miss("line1 word 0x10", 21'h000010, 2'b00, 32'h10081009);
    read_miss("line0 word 0x4", 21'h000004, 2'b00, 32'h10021003);

    for (int i = 0; i < NV; i++) begin
      busEnable = vecs[i].en; busWrite = vecs[i].wr; busAccessSize = vecs[i].sz;
      busAddress = vecs[i].addr; busWriteData = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d wait", i), {31'd0, busWait}, {31'd0, vecs[i].exp_wait});
      if (vecs[i].chk_data) check($sformatf("vec%0d data", i), busReadData, vecs[i].exp_data);
      check($sformatf("vec%0d ce/we high", i), {30'd0, ce_n, we_n}, 32'd3);
      tick();
    end
    busEnable = 1'b0; busWrite = 1'b0;
    tick();

    // busEnable dropped mid-fill: the fill still completes and the line becomes valid.
    busEnable = 1'b1; busAddress = 21'h000020; busAccessSize = 2'b00;
    repeat (5) tick();
    busEnable = 1'b0;
    #1;
    check("drop: wait low when idle bus", {31'd0, busWait}, 32'd0);
    check("drop: data zero when idle bus", busReadData, 32'd0);
    repeat (40) tick();
    check("drop: ce high after fill", {31'd0, ce_n}, 32'd1);
    busEnable = 1'b1; busAddress = 21'h000024;
    #1;
    check("drop: line hit wait", {31'd0, busWait}, 32'd0);
    check("drop: line hit data", busReadData, 32'h10121013);
    tick();
    busEnable = 1'b0;
    tick();

    // Reset ten cycles into a fill.
    busEnable = 1'b1; busAddress = 21'h000040; busAccessSize = 2'b00;
    repeat (10) tick();
    check("mid-fill ce low", {31'd0, ce_n}, 32'd0);
    reset = 1'b1;
    tick();
    check("mid-fill reset ce/oe high", {30'd0, ce_n, oe_n}, 32'd3);
    check("mid-fill reset rom reset low", {31'd0, rst_n}, 32'd0);
    check("mid-fill reset busWait", {31'd0, busWait}, 32'd1);
    check("mid-fill reset rom address", 32'(romAddress), 32'd0);
    reset = 1'b0;
    measure_pulse("re-reset");
    read_miss("line4 after reset", 21'h000040, 2'b00, 32'h10201021);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
